// File: rtl/mpu_6050_poll_seq_if.sv
// Request/response bus between the poll sequencer and the top_mpu_6050 controller.
interface mpu_6050_poll_seq_if;
  logic        en;
  logic [9:0]  instr;
  logic        busy;
  logic        err;
  logic [23:0] rxd;

  modport master (output en, instr, input busy, err, rxd);
  modport slave  (input en, instr, output busy, err, rxd);
endinterface

// File: rtl/mpu_6050_poll_seq.sv
// Periodic 3-channel read sequencer for top_mpu_6050 with per-channel retry and timeout.
// Optional MPU_POLL_TSTAMP_EN adds a 32-bit cycle timestamp latched with each frame.
module mpu_6050_poll_seq #(
  parameter int          FPGA_CLK    = 50_000_000,
  parameter int          POLL_HZ     = 100,
  parameter logic [9:0]  INSTR_CH0   = 10'h03B,
  parameter logic [9:0]  INSTR_CH1   = 10'h03D,
  parameter logic [9:0]  INSTR_CH2   = 10'h03F,
  parameter int          TIMEOUT_CYC = 100_000,
  parameter int          MAX_RETRY   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  mpu_6050_poll_seq_if.master bus,
  output logic [15:0]         ch0,
  output logic [15:0]         ch1,
  output logic [15:0]         ch2,
  output logic                valid,
  output logic                frame_err,
  output logic [7:0]          err_cnt
`ifdef MPU_POLL_TSTAMP_EN
  ,
  output logic [31:0]         tstamp
`endif
);
  localparam int PERIOD = FPGA_CLK / POLL_HZ;
  localparam int TW     = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam int TMW    = $clog2(TIMEOUT_CYC + 1);
  localparam int RW     = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {IDLE, ARM, ISSUE, WAIT_HI, WAIT_LO, DONE, NEXT} state_t;

  state_t              state;
  logic [TW-1:0]       tick_cnt;
  logic                tick;
  logic [1:0]          ch;
  logic [RW-1:0]       retry;
  logic [TMW-1:0]      tmo_cnt;
  logic                tmo_hit;
  logic                tmo_expired;
  logic                xfer_ok;
  logic                publish;
  logic [9:0]          instr_sel;
  logic [1:0][15:0]    shadow;
  logic                unused_rxd_hi;

  assign unused_rxd_hi = ^bus.rxd[23:16];

  // Free-running frame tick; held at zero while polling is disabled.
  assign tick = run && (tick_cnt == TW'(PERIOD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tick_cnt <= '0;
    else if (!run) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  always_comb begin
    instr_sel = INSTR_CH0;
    case (ch)
      2'd1:    instr_sel = INSTR_CH1;
      2'd2:    instr_sel = INSTR_CH2;
      default: instr_sel = INSTR_CH0;
    endcase
  end

  assign tmo_expired = (tmo_cnt == TMW'(TIMEOUT_CYC - 1));
  assign xfer_ok     = !tmo_hit && !bus.err;
  // The last channel's data goes straight to the outputs so valid lands one cycle after DONE.
  assign publish     = (state == DONE) && xfer_ok && (ch == 2'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ch        <= '0;
      retry     <= '0;
      tmo_cnt   <= '0;
      tmo_hit   <= 1'b0;
      shadow    <= '0;
      bus.en    <= 1'b0;
      bus.instr <= '0;
      ch0       <= '0;
      ch1       <= '0;
      ch2       <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      bus.en <= 1'b0;
      valid  <= 1'b0;
      case (state)
        IDLE: if (tick) begin
          ch    <= '0;
          retry <= '0;
          state <= ARM;
        end
        ARM: if (!bus.busy) begin
          bus.en    <= 1'b1;
          bus.instr <= instr_sel;
          tmo_cnt   <= '0;
          tmo_hit   <= 1'b0;
          state     <= ISSUE;
        end
        ISSUE: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          state   <= WAIT_HI;
        end
        WAIT_HI: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (tmo_expired) begin
            tmo_hit <= 1'b1;
            state   <= DONE;
          end else if (bus.busy) state <= WAIT_LO;
        end
        WAIT_LO: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (tmo_expired) begin
            tmo_hit <= 1'b1;
            state   <= DONE;
          end else if (!bus.busy) state <= DONE;
        end
        DONE: begin
          if (xfer_ok) begin
            retry <= '0;
            if (ch != 2'd2) shadow[ch[0]] <= bus.rxd[15:0];
            if (publish) begin
              ch0       <= shadow[0];
              ch1       <= shadow[1];
              ch2       <= bus.rxd[15:0];
              valid     <= 1'b1;
              frame_err <= 1'b0;
            end
            state <= NEXT;
          end else begin
            // A timeout coinciding with err still counts as a single failed attempt.
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            if (retry < RW'(MAX_RETRY)) begin
              retry <= retry + 1'b1;
              state <= ARM;
            end else begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        NEXT: begin
          if (ch == 2'd2) state <= IDLE;
          else begin
            ch    <= ch + 2'd1;
            state <= ARM;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MPU_POLL_TSTAMP_EN
  logic [31:0] cyc_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt <= '0;
      tstamp  <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (publish) tstamp <= cyc_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_mpu_6050_poll_seq.sv
// Directed bench for mpu_6050_poll_seq with a top_mpu_6050 behavioural model (busy 20 cycles after en).
module tb_mpu_6050_poll_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [15:0] ch0, ch1, ch2;
  logic        valid, frame_err;
  logic [7:0]  err_cnt;
`ifdef MPU_POLL_TSTAMP_EN
  logic [31:0] tstamp;
`endif

  mpu_6050_poll_seq_if bus();

  mpu_6050_poll_seq #(
    .FPGA_CLK(50_000_000), .POLL_HZ(50_000), .TIMEOUT_CYC(200), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .bus(bus),
    .ch0(ch0), .ch1(ch1), .ch2(ch2),
    .valid(valid), .frame_err(frame_err), .err_cnt(err_cnt)
`ifdef MPU_POLL_TSTAMP_EN
    , .tstamp(tstamp)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] rsp_data [3];
  int          fail_left [3];
  bit          no_busy = 1'b0;
  int          en_cnt = 0;
  int          valid_cnt = 0;
  logic [9:0]  instr_log [$];

  localparam int W_VALID = 0, W_FERR = 1, W_ERRCNT = 2, W_BUSY = 3, W_EN = 4, W_ERRNE = 5;

  function automatic int instr_idx(input logic [9:0] ins);
    case (ins)
      10'h03D: return 1;
      10'h03F: return 2;
      default: return 0;
    endcase
  endfunction

  // Controller model: busy rises 20 cycles after en, falls 5 cycles later with err/rxd.
  initial begin
    int idx;
    bus.busy = 1'b0; bus.err = 1'b0; bus.rxd = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.en) begin
        idx = instr_idx(bus.instr);
        if (!no_busy) begin
          repeat (20) @(posedge clk);
          #1 bus.busy = 1'b1;
          repeat (5) @(posedge clk);
          #1 bus.busy = 1'b0;
          if (fail_left[idx] > 0) begin
            bus.err = 1'b1;
            fail_left[idx] = fail_left[idx] - 1;
          end else bus.err = 1'b0;
          bus.rxd = {8'hA5, rsp_data[idx]};
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (bus.en) begin
        en_cnt = en_cnt + 1;
        instr_log.push_back(bus.instr);
      end
      if (valid) valid_cnt = valid_cnt + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_for(input int what, input logic [31:0] val, input int budget, output bit ok);
    bit hit;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      case (what)
        W_VALID:  hit = (valid === 1'b1);
        W_FERR:   hit = (frame_err === 1'b1);
        W_ERRCNT: hit = (err_cnt === val[7:0]);
        W_BUSY:   hit = (bus.busy === 1'b1);
        W_EN:     hit = (bus.en === 1'b1) && (bus.instr === val[9:0]);
        default:  hit = (err_cnt !== val[7:0]);
      endcase
      if (hit) begin ok = 1'b1; break; end
    end
  endtask

  task automatic check_log(input string tag, input int n, input logic [9:0] e0, e1, e2, e3, e4);
    logic [9:0] e [5];
    e = '{e0, e1, e2, e3, e4};
    check({tag, "_len"}, instr_log.size(), n);
    for (int i = 0; i < n && i < instr_log.size(); i++)
      check($sformatf("%s_%0d", tag, i), {22'd0, instr_log[i]}, {22'd0, e[i]});
  endtask

  task automatic clear_logs();
    instr_log.delete();
    en_cnt = 0;
    valid_cnt = 0;
  endtask

  initial begin
    bit ok;
    int c0, c1;
`ifdef MPU_POLL_TSTAMP_EN
    logic [31:0] ts_a;
`endif
    fail_left = '{0, 0, 0};
    rsp_data  = '{16'h1234, 16'hFFFE, 16'h4000};

    // Reset state
    step(3);
    check("rst_en", bus.en, 0);
    check("rst_valid", valid, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_errcnt", err_cnt, 0);
    check("rst_ch0", ch0, 0);
    check("rst_ch2", ch2, 0);
    rst = 1'b0;
    step(2);

    // 1. Clean frame
    clear_logs();
    run = 1'b1;
    wait_for(W_VALID, 0, 3000, ok);
    check("t1_valid_seen", ok, 1);
    run = 1'b0;
    step(5);
    check("t1_ch0", ch0, 16'h1234);
    check("t1_ch1", ch1, 16'hFFFE);
    check("t1_ch2", ch2, 16'h4000);
    check("t1_valid_cnt", valid_cnt, 1);
    check("t1_errcnt", err_cnt, 0);
    check("t1_ferr", frame_err, 0);
    check_log("t1_instr", 3, 10'h03B, 10'h03D, 10'h03F, 10'h0, 10'h0);

    // 2. CH1 fails once then succeeds
    clear_logs();
    rsp_data = '{16'h0001, 16'h8000, 16'h7FFF};
    fail_left = '{0, 1, 0};
    run = 1'b1;
    wait_for(W_VALID, 0, 3000, ok);
    check("t2_valid_seen", ok, 1);
    run = 1'b0;
    step(5);
    check("t2_ch0", ch0, 16'h0001);
    check("t2_ch1", ch1, 16'h8000);
    check("t2_ch2", ch2, 16'h7FFF);
    check("t2_errcnt", err_cnt, 1);
    check("t2_ferr", frame_err, 0);
    check("t2_valid_cnt", valid_cnt, 1);
    check_log("t2_instr", 4, 10'h03B, 10'h03D, 10'h03D, 10'h03F, 10'h0);

    // 3. CH2 exhausts retries; outputs keep the previous frame
    clear_logs();
    rsp_data = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    fail_left = '{0, 0, 3};
    run = 1'b1;
    wait_for(W_FERR, 0, 3000, ok);
    check("t3_ferr_seen", ok, 1);
    step(3);
    run = 1'b0;
    step(5);
    check("t3_errcnt", err_cnt, 4);
    check("t3_valid_cnt", valid_cnt, 0);
    check("t3_ch0", ch0, 16'h0001);
    check("t3_ch1", ch1, 16'h8000);
    check("t3_ch2", ch2, 16'h7FFF);
    check_log("t3_instr", 5, 10'h03B, 10'h03D, 10'h03F, 10'h03F, 10'h03F);

    // 4. Busy never rises: each attempt times out 200 cycles after en
    clear_logs();
    no_busy = 1'b1;
    run = 1'b1;
    wait_for(W_EN, 10'h03B, 1500, ok);
    check("t4_en_seen", ok, 1);
    c0 = cyc;
    wait_for(W_ERRNE, 4, 500, ok);
    c1 = cyc;
    check("t4_tmo_seen", ok, 1);
    check("t4_tmo_latency", c1 - c0, 201);
    wait_for(W_ERRCNT, 7, 1000, ok);
    check("t4_errcnt_seen", ok, 1);
    step(3);
    run = 1'b0;
    step(5);
    check("t4_errcnt", err_cnt, 7);
    check("t4_ferr", frame_err, 1);
    check("t4_valid_cnt", valid_cnt, 0);
    check_log("t4_instr", 3, 10'h03B, 10'h03B, 10'h03B, 10'h0, 10'h0);
    no_busy = 1'b0;

    // 5a. Drop run during CH1: frame completes, then no further requests
    clear_logs();
    rsp_data = '{16'h1111, 16'h2222, 16'h3333};
    run = 1'b1;
    wait_for(W_EN, 10'h03D, 1500, ok);
    check("t5_ch1_issue", ok, 1);
    run = 1'b0;
    wait_for(W_VALID, 0, 500, ok);
    check("t5_valid_seen", ok, 1);
    step(2);
    check("t5_ch2", ch2, 16'h3333);
    check("t5_ferr_cleared", frame_err, 0);
    en_cnt = 0;
    step(2500);
    check("t5_no_en_after_stop", en_cnt, 0);

    // 5b. Reset in WAIT_LO clears outputs at once; nothing issued before the next tick
    run = 1'b1;
    wait_for(W_BUSY, 0, 1500, ok);
    check("t5_busy_seen", ok, 1);
    step(2);
    rst = 1'b1;
    #1;
    check("t5r_ch0", ch0, 0);
    check("t5r_ch1", ch1, 0);
    check("t5r_ch2", ch2, 0);
    check("t5r_errcnt", err_cnt, 0);
    check("t5r_valid", valid, 0);
    check("t5r_en", bus.en, 0);
    step(2);
    rsp_data = '{16'h0A0A, 16'h0B0B, 16'h0C0C};
    rst = 1'b0;
    en_cnt = 0;
    step(900);
    check("t5r_no_en_before_tick", en_cnt, 0);
    wait_for(W_VALID, 0, 500, ok);
    check("t5r_valid_seen", ok, 1);
    check("t5r_new_ch0", ch0, 16'h0A0A);
    check("t5r_new_ch2", ch2, 16'h0C0C);
    check("t5r_errcnt_after", err_cnt, 0);

`ifdef MPU_POLL_TSTAMP_EN
    // 6. Back-to-back frames are one tick period apart
    ts_a = tstamp;
    wait_for(W_VALID, 0, 1500, ok);
    check("t6_valid_seen", ok, 1);
    check("t6_tstamp_delta", tstamp - ts_a, 1000);
`endif

    run = 1'b0;
    step(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
